// File: rtl/gcn_transform_act_engine_pkg.sv
// gcn_ta_pkg: shared FSM states and sizing/saturation helpers for the transform+activation engine.
// Rev 1.0
`default_nettype none

package gcn_ta_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_READY = 3'd2,
      S_ACC   = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   function automatic int acc_width(input int data_w, input int feat_len);
      return 2 * data_w + $clog2(feat_len);
   endfunction

   function automatic int chunks(input int feat_len, input int psys);
      return feat_len / psys;
   endfunction

   // Clamp to the signed range of a data_w-bit word; result stays sign-extended.
   function automatic logic signed [127:0] sat_to_data(input logic signed [127:0] v,
                                                       input int data_w);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (data_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gcn_transform_act_engine_if.sv
// gcn_transform_act_engine_if: control, weight, feature and output streams of the engine.
// Rev 1.0
`default_nettype none

interface gcn_transform_act_engine_if #(
   parameter int DATA_W = 32,
   parameter int PSYS   = 32,
   parameter int K      = 1024
);
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

   logic                   mode;
   logic                   load_start;
   logic                   w_valid;
   logic                   w_ready;
   logic [PSYS*DATA_W-1:0] w_data;
   logic                   x_valid;
   logic                   x_ready;
   logic [PSYS*DATA_W-1:0] x_data;
   logic                   x_last;
   logic                   y_valid;
   logic                   y_ready;
   logic [PSYS*DATA_W-1:0] y_data;
   logic [IDX_W-1:0]       y_row_idx;
   logic                   weights_loaded;
   logic                   err_last;

   modport slave (
      input  mode, load_start, w_valid, w_data, x_valid, x_data, x_last, y_ready,
      output w_ready, x_ready, y_valid, y_data, y_row_idx, weights_loaded, err_last
   );

   modport master (
      output mode, load_start, w_valid, w_data, x_valid, x_data, x_last, y_ready,
      input  w_ready, x_ready, y_valid, y_data, y_row_idx, weights_loaded, err_last
   );

endinterface

`default_nettype wire

// File: rtl/gcn_transform_act_engine_act_lane.sv
// gcn_act_lane: one word of shift, signed saturation and optional activation (ReLU, or leaky
// ReLU when GCN_TA_LEAKY_RELU_EN is defined). Rev 1.0
`default_nettype none

module gcn_act_lane
   import gcn_ta_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int IN_W        = 32,
   parameter int SHIFT       = 0,
   parameter int LEAKY_SHIFT = 3
) (
   input  logic signed [IN_W-1:0]   in_i,
   input  logic                     act_en_i,
   output logic signed [DATA_W-1:0] out_o
);

`ifdef GCN_TA_LEAKY_RELU_EN
   localparam bit LEAKY_EN = 1'b1;
`else
   localparam bit LEAKY_EN = 1'b0;
`endif

   logic signed [IN_W-1:0]   shifted;
   logic signed [127:0]      ext;
   logic signed [DATA_W-1:0] sat;
   logic signed [DATA_W-1:0] neg_val;

   assign shifted = in_i >>> SHIFT;
   assign ext     = shifted;
   assign sat     = DATA_W'(sat_to_data(ext, DATA_W));
   assign neg_val = LEAKY_EN ? (sat >>> LEAKY_SHIFT) : '0;
   assign out_o   = (act_en_i && sat < 0) ? neg_val : sat;

endmodule

`default_nettype wire

// File: rtl/gcn_transform_act_engine.sv
// gcn_transform_act_engine: stationary-weight row transform y=act(x*W) / y=act(x)*W.
// Optional leaky activation via GCN_TA_LEAKY_RELU_EN. Rev 1.0
`default_nettype none

module gcn_transform_act_engine
   import gcn_ta_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int PSYS        = 32,
   parameter int FEAT_LEN    = 128,
   parameter int K           = 1024,
   parameter int FRAC_BITS   = 16,
   parameter int LEAKY_SHIFT = 3
) (
   input logic                    clk,
   input logic                    rst,
   gcn_transform_act_engine_if.slave bus
);

   localparam int CHUNKS = chunks(FEAT_LEN, PSYS);
   localparam int ACC_W  = acc_width(DATA_W, FEAT_LEN);
   localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;
   localparam int LW     = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int SW     = (PSYS > 1) ? $clog2(PSYS) : 1;

   if ((FEAT_LEN % PSYS) != 0) begin : g_len_check
      $error("FEAT_LEN must be a multiple of PSYS");
   end

   state_t                   state_q;
   logic [LW-1:0]            wcnt_q;
   logic [CW-1:0]            c_q;
   logic                     mode_q;
   logic signed [ACC_W-1:0]  acc_q [PSYS];
   logic signed [ACC_W-1:0]  acc_d [PSYS];
   logic [PSYS*DATA_W-1:0]   y_data_q;
   logic                     y_valid_q;
   logic [IDX_W-1:0]         idx_q;
   logic                     wl_q;
   logic                     err_q;
   logic                     w_ready_q;
   logic                     x_ready_q;
   logic [PSYS*DATA_W-1:0]   w_mem_q [CHUNKS][PSYS];

   logic signed [DATA_W-1:0] pre [PSYS];
   logic [PSYS*DATA_W-1:0]   y_next;
   logic                     w_acc;
   logic                     x_acc;
   logic                     first;
   logic [CW-1:0]            cur_c;
   logic                     eff_mode;
   logic                     final_beat;

   // load_start wins over a same-cycle beat, so it masks the ready it competes with.
   assign bus.w_ready = w_ready_q & ~bus.load_start;
   assign bus.x_ready = x_ready_q & ~(bus.load_start & (state_q == S_READY));

   assign w_acc      = bus.w_valid & bus.w_ready;
   assign x_acc      = bus.x_valid & bus.x_ready;
   assign first      = (state_q == S_READY);
   assign cur_c      = first ? '0 : c_q;
   assign eff_mode   = first ? bus.mode : mode_q;
   assign final_beat = (cur_c == CW'(CHUNKS - 1));

   for (genvar i = 0; i < PSYS; i++) begin : g_pre
      gcn_act_lane #(
         .DATA_W      (DATA_W),
         .IN_W        (DATA_W),
         .SHIFT       (0),
         .LEAKY_SHIFT (LEAKY_SHIFT)
      ) u_pre (
         .in_i     (bus.x_data[i*DATA_W +: DATA_W]),
         .act_en_i (eff_mode),
         .out_o    (pre[i])
      );
   end

   for (genvar j = 0; j < PSYS; j++) begin : g_post
      gcn_act_lane #(
         .DATA_W      (DATA_W),
         .IN_W        (ACC_W),
         .SHIFT       (FRAC_BITS),
         .LEAKY_SHIFT (LEAKY_SHIFT)
      ) u_post (
         .in_i     (acc_d[j]),
         .act_en_i (~eff_mode),
         .out_o    (y_next[j*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      for (int j = 0; j < PSYS; j++) begin
         acc_d[j] = first ? '0 : acc_q[j];
         for (int i = 0; i < PSYS; i++) begin
            acc_d[j] = acc_d[j] + ACC_W'(pre[i]) *
                       ACC_W'($signed(w_mem_q[cur_c][i][j*DATA_W +: DATA_W]));
         end
      end
   end

   // Weight tile carries no reset: weights_loaded gates its use.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         w_mem_q[CW'(wcnt_q / PSYS)][SW'(wcnt_q % PSYS)] <= bus.w_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         wcnt_q    <= '0;
         c_q       <= '0;
         mode_q    <= 1'b0;
         acc_q     <= '{default: '0};
         y_data_q  <= '0;
         y_valid_q <= 1'b0;
         idx_q     <= '0;
         wl_q      <= 1'b0;
         err_q     <= 1'b0;
         w_ready_q <= 1'b0;
         x_ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.load_start) begin
                  state_q   <= S_LOAD;
                  wcnt_q    <= '0;
                  wl_q      <= 1'b0;
                  w_ready_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (bus.load_start) begin
                  wcnt_q <= '0;
               end else if (w_acc) begin
                  if (wcnt_q == LW'(FEAT_LEN - 1)) begin
                     state_q   <= S_READY;
                     wl_q      <= 1'b1;
                     w_ready_q <= 1'b0;
                     x_ready_q <= 1'b1;
                  end else begin
                     wcnt_q <= wcnt_q + LW'(1);
                  end
               end
            end
            S_READY, S_ACC: begin
               if (first && bus.load_start) begin
                  state_q   <= S_LOAD;
                  wcnt_q    <= '0;
                  wl_q      <= 1'b0;
                  w_ready_q <= 1'b1;
                  x_ready_q <= 1'b0;
               end else if (x_acc) begin
                  acc_q <= acc_d;
                  if (first) mode_q <= bus.mode;
                  if (bus.x_last != final_beat) err_q <= 1'b1;
                  if (final_beat) begin
                     state_q   <= S_OUT;
                     c_q       <= '0;
                     x_ready_q <= 1'b0;
                     y_valid_q <= 1'b1;
                     y_data_q  <= y_next;
                  end else begin
                     state_q <= S_ACC;
                     c_q     <= cur_c + CW'(1);
                  end
               end
            end
            S_OUT: begin
               if (bus.y_ready) begin
                  state_q   <= S_READY;
                  y_valid_q <= 1'b0;
                  x_ready_q <= 1'b1;
                  idx_q     <= (idx_q == IDX_W'(K - 1)) ? '0 : idx_q + IDX_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.y_valid        = y_valid_q;
   assign bus.y_data         = y_data_q;
   assign bus.y_row_idx      = idx_q;
   assign bus.weights_loaded = wl_q;
   assign bus.err_last       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gcn_transform_act_engine.sv
// tb_gcn_transform_act_engine: randomized self-checking bench with a row-level reference model.
// Rev 1.0
`default_nettype none

module tb_gcn_transform_act_engine;

   localparam int DW = 16;
   localparam int P  = 4;
   localparam int FL = 8;
   localparam int KK = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gcn_transform_act_engine_if #(.DATA_W(DW), .PSYS(P), .K(KK)) bus ();

   gcn_transform_act_engine #(
      .DATA_W(DW), .PSYS(P), .FEAT_LEN(FL), .K(KK), .FRAC_BITS(0), .LEAKY_SHIFT(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int w_m [FL][P];
   int x_m [FL];
   int y_e [P];
   int exp_idx = 0;

   function automatic int act(input int v);
      if (v < 0) begin
`ifdef GCN_TA_LEAKY_RELU_EN
         return v >>> 3;
`else
         return 0;
`endif
      end
      return v;
   endfunction

   function automatic int sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic void compute_ref(input bit md);
      for (int j = 0; j < P; j++) begin
         longint s = 0;
         for (int i = 0; i < FL; i++) begin
            int pv = md ? act(x_m[i]) : x_m[i];
            s += longint'(pv) * longint'(w_m[i][j]);
         end
         y_e[j] = md ? sat16(s) : act(sat16(s));
      end
   endfunction

   function automatic logic [P*DW-1:0] pack_y();
      logic [P*DW-1:0] v;
      for (int j = 0; j < P; j++) v[j*DW +: DW] = y_e[j][DW-1:0];
      return v;
   endfunction

   task automatic set_identity();
      for (int r = 0; r < FL; r++)
         for (int j = 0; j < P; j++) w_m[r][j] = (r < P && r == j) ? 1 : 0;
   endtask

   task automatic load_weights(input bit do_pulse, input bit check_wl);
      int n;
      if (do_pulse) begin
         @(negedge clk);
         bus.load_start = 1'b1;
         @(negedge clk);
         bus.load_start = 1'b0;
      end
      for (int r = 0; r < FL; r++) begin
         for (int j = 0; j < P; j++) bus.w_data[j*DW +: DW] = w_m[r][j][DW-1:0];
         bus.w_valid = 1'b1;
         n = 0;
         #1;
         while (!bus.w_ready && n < 50) begin
            @(negedge clk); #1; n++;
         end
         if (n >= 50) begin
            errors++; checks++;
            $display("FAIL load_timeout: w_ready never rose at beat %0d", r);
            break;
         end
         if (check_wl) begin
            checks++;
            if (bus.weights_loaded !== 1'b0) begin
               errors++;
               $display("FAIL wl_during_load: beat %0d got %b expected 0", r, bus.weights_loaded);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.w_valid = 1'b0;
      checks++;
      if (bus.weights_loaded !== 1'b1) begin
         errors++;
         $display("FAIL wl_after_load: got %b expected 1", bus.weights_loaded);
      end
   endtask

   // Drives one row, checks latency, data, index and accepts it after hold cycles.
   task automatic run_row(input string nm, input bit md, input bit l0, input bit l1,
                          input int hold, input bit pulse_mid);
      int n;
      logic [P*DW-1:0] ey;
      compute_ref(md);
      ey = pack_y();
      bus.mode = md;
      for (int b = 0; b < FL / P; b++) begin
         for (int i = 0; i < P; i++) bus.x_data[i*DW +: DW] = x_m[b*P+i][DW-1:0];
         bus.x_last  = b == 0 ? l0 : l1;
         bus.x_valid = 1'b1;
         n = 0;
         #1;
         while (!bus.x_ready && n < 50) begin
            @(negedge clk); #1; n++;
         end
         if (n >= 50) begin
            errors++; checks++;
            $display("FAIL %s_x_timeout: x_ready never rose at beat %0d", nm, b);
         end
         if (b == FL / P - 1) begin
            checks++;
            if (bus.y_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s_early_valid: got %b expected 0", nm, bus.y_valid);
            end
         end
         @(posedge clk);
         @(negedge clk);
         bus.x_valid = 1'b0;
         bus.x_last  = 1'b0;
         if (pulse_mid && b == 0) begin
            bus.load_start = 1'b1;
            @(negedge clk);
            bus.load_start = 1'b0;
            #1;
            checks++;
            if (bus.w_ready !== 1'b0 || bus.weights_loaded !== 1'b1) begin
               errors++;
               $display("FAIL %s_load_in_acc: w_ready=%b wl=%b expected 0/1", nm,
                        bus.w_ready, bus.weights_loaded);
            end
         end
      end
      checks++;
      if (bus.y_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency: y_valid got %b expected 1", nm, bus.y_valid);
      end
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if (bus.y_data !== ey || bus.y_row_idx !== 2'(exp_idx) || bus.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_y: data=%h idx=%0d v=%b expected %h idx=%0d v=1", nm,
                     bus.y_data, bus.y_row_idx, bus.y_valid, ey, exp_idx);
         end
         if (h > 0) begin
            checks++;
            if (bus.x_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s_hold_xready: got %b expected 0", nm, bus.x_ready);
            end
         end
         if (h < hold) @(negedge clk);
      end
      bus.y_ready = 1'b1;
      @(negedge clk);
      bus.y_ready = 1'b0;
      exp_idx = (exp_idx + 1) % KK;
      checks++;
      if (bus.y_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_valid_drop: got %b expected 0", nm, bus.y_valid);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (bus.y_valid !== 1'b0 || bus.y_data !== '0 || bus.y_row_idx !== '0 ||
          bus.weights_loaded !== 1'b0 || bus.err_last !== 1'b0 ||
          bus.w_ready !== 1'b0 || bus.x_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: v=%b d=%h idx=%0d wl=%b err=%b wr=%b xr=%b expected all 0",
                  bus.y_valid, bus.y_data, bus.y_row_idx, bus.weights_loaded, bus.err_last,
                  bus.w_ready, bus.x_ready);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      set_identity();
      load_weights(1'b1, 1'b1);
      x_m = '{1, -2, 3, 4, 9, 9, 9, 9};
      run_row("ident_m0", 1'b0, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_mode1();
      x_m = '{-5, 6, -7, 8, 0, 0, 0, 0};
      run_row("ident_m1", 1'b1, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_saturation();
      for (int r = 0; r < FL; r++) for (int j = 0; j < P; j++) w_m[r][j] = 32767;
      load_weights(1'b1, 1'b0);
      for (int i = 0; i < FL; i++) x_m[i] = 32767;
      run_row("sat_pos", 1'b0, 1'b0, 1'b1, 0, 1'b0);
      for (int i = 0; i < FL; i++) x_m[i] = -32768;
      run_row("sat_neg", 1'b0, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < FL; r++)
         for (int j = 0; j < P; j++) w_m[r][j] = int'($urandom_range(0, 511)) - 256;
      load_weights(1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < FL; i++) x_m[i] = int'($urandom_range(0, 65535)) - 32768;
         run_row("random", 1'($urandom_range(0, 1)), 1'b0, 1'b1, 0, 1'b0);
      end
   endtask

   task automatic test_hold_and_wrap();
      set_identity();
      load_weights(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < FL; i++) x_m[i] = int'($urandom_range(0, 200)) - 100;
         run_row("hold_wrap", 1'b0, 1'b0, 1'b1, (k == 0) ? 5 : 0, 1'b0);
      end
   endtask

   task automatic test_err_last();
      checks++;
      if (bus.err_last !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got %b expected 0", bus.err_last);
      end
      x_m = '{10, -3, 2, 7, 1, 1, 1, 1};
      run_row("err_last_row", 1'b0, 1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (bus.err_last !== 1'b1) begin
         errors++;
         $display("FAIL err_after: got %b expected 1", bus.err_last);
      end
   endtask

   task automatic test_load_in_acc();
      x_m = '{3, 5, -1, 2, 4, 4, 4, 4};
      run_row("load_in_acc", 1'b1, 1'b0, 1'b1, 0, 1'b1);
   endtask

   task automatic test_reload();
      for (int r = 0; r < FL; r++)
         for (int j = 0; j < P; j++) w_m[r][j] = int'($urandom_range(0, 63)) - 32;
      @(negedge clk);
      bus.x_valid    = 1'b1;
      bus.load_start = 1'b1;
      #1;
      checks++;
      if (bus.x_ready !== 1'b0) begin
         errors++;
         $display("FAIL reload_priority: x_ready got %b expected 0", bus.x_ready);
      end
      @(negedge clk);
      bus.x_valid    = 1'b0;
      bus.load_start = 1'b0;
      load_weights(1'b0, 1'b1);
      for (int i = 0; i < FL; i++) x_m[i] = int'($urandom_range(0, 255)) - 128;
      run_row("reload_row", 1'b0, 1'b0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_reset_mid_row();
      for (int i = 0; i < P; i++) bus.x_data[i*DW +: DW] = 16'(i + 1);
      bus.x_valid = 1'b1;
      bus.mode    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.x_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.y_valid !== 1'b0 || bus.y_data !== '0 || bus.y_row_idx !== '0 ||
          bus.weights_loaded !== 1'b0 || bus.err_last !== 1'b0 || bus.x_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: v=%b d=%h idx=%0d wl=%b err=%b xr=%b expected all 0",
                  bus.y_valid, bus.y_data, bus.y_row_idx, bus.weights_loaded, bus.err_last,
                  bus.x_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_idx = 0;
      bus.x_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.x_ready !== 1'b0 || bus.weights_loaded !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: xr=%b wl=%b expected 0/0", bus.x_ready,
                     bus.weights_loaded);
         end
      end
      bus.x_valid = 1'b0;
      set_identity();
      load_weights(1'b1, 1'b0);
      x_m = '{-4, 8, 15, -16, 23, 42, 0, 1};
      run_row("after_reset", 1'b0, 1'b0, 1'b1, 0, 1'b0);
   endtask

   initial begin
      bus.mode = 1'b0;
      bus.load_start = 1'b0;
      bus.w_valid = 1'b0;
      bus.w_data = '0;
      bus.x_valid = 1'b0;
      bus.x_data = '0;
      bus.x_last = 1'b0;
      bus.y_ready = 1'b0;
      test_reset();
      test_identity();
      test_mode1();
      test_saturation();
      test_random();
      test_hold_and_wrap();
      test_err_last();
      test_load_in_acc();
      test_reload();
      test_reset_mid_row();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/gcn_transform_act_engine.md
Name: gcn_transform_act_engine

Overview:
- Streaming feature-transformation plus activation stage for the GCN training datapath: y = act(x·W) or y = act(x)·W per vertex row.
- Holds a stationary FEAT_LEN×PSYS weight tile loaded over a handshake.
- Consumes aggregated feature rows PSYS words per beat and accumulates over FEAT_LEN/PSYS beats.
- Emits one PSYS-wide output row with valid/ready backpressure and a wrapping row index toward the next layer buffer.

Parameters:
- DATA_W, 32, signed two's-complement word width.
- PSYS, 32, words per beat and output columns.
- FEAT_LEN, 128, input feature length; must be a multiple of PSYS, checked by elaboration assertion.
- K, 1024, rows per batch; y_row_idx wraps at K.
- FRAC_BITS, 16, fixed-point fraction bits; accumulator is arithmetic-shifted right by this before saturation.
- LEAKY_SHIFT, 3, negative-slope shift; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0: y=act(x·W); 1: y=act(x)·W, no post-activation. Sampled on the first beat of each row.
- load_start  in  1  pulse; begins weight reload.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid&&w_ready.
- w_data  in  PSYS*DATA_W  one weight row W[r][0..PSYS-1]; word j at bits [j*DATA_W +: DATA_W].
- x_valid  in  1  feature beat valid.
- x_ready  out  1  feature beat accepted.
- x_data  in  PSYS*DATA_W  feature words x[c*PSYS+i].
- x_last  in  1  marks final beat of a row.
- y_valid  out  1  output row valid.
- y_ready  in  1  downstream accept.
- y_data  out  PSYS*DATA_W  output row.
- y_row_idx  out  clog2(K)  index of the row on y_data.
- weights_loaded  out  1  weight tile complete and valid.
- err_last  out  1  sticky; x_last disagreed with the beat count.

Behaviour:
- Constants: CHUNKS=FEAT_LEN/PSYS; ACC_W=2*DATA_W+clog2(FEAT_LEN). Weight store is CHUNKS entries of PSYS*PSYS words.
- Reset values: all outputs 0, state S_IDLE, counters 0, accumulators 0.
- S_IDLE: w_ready=0, x_ready=0. load_start → S_LOAD.
- S_LOAD:
  - weights_loaded cleared on entry; w_ready=1.
  - Beat r (0..FEAT_LEN-1) is written to chunk r/PSYS, sub-row r%PSYS.
  - Accepted beat FEAT_LEN-1 → S_READY, weights_loaded=1 next cycle.
  - load_start during S_LOAD restarts the count at 0.
- S_READY:
  - x_ready=1.
  - load_start → S_LOAD. load_start has priority over a same-cycle x beat; that beat is not accepted.
  - First accepted beat latches mode, clears the accumulators, adds its chunk-0 products, and goes to S_ACC (or straight to S_OUT if CHUNKS==1).
- S_ACC:
  - x_ready=1; each accepted beat c adds sum_i pre(x_i)·W[c*PSYS+i][j] into acc[j] for all j in 0..PSYS-1.
  - pre() is the activation in mode 1 and identity in mode 0.
  - The beat with c==CHUNKS-1 → S_OUT.
  - load_start is ignored in S_ACC and S_OUT.
- x_last check: if x_last!=(c==CHUNKS-1), err_last←1 (sticky until reset). The beat count alone governs row completion.
- Output:
  - Output register is loaded the cycle after the final beat is accepted; y_valid rises that cycle. Latency is 1 cycle from the final beat.
  - Per lane: (acc>>>FRAC_BITS), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Then ReLU in mode 0; mode 1 has no post-activation.
- S_OUT:
  - x_ready=0; y_data and y_row_idx are held stable while y_valid && !y_ready.
  - On y_ready, y_valid falls the next cycle, y_row_idx increments (K-1 wraps to 0), and the state → S_READY.
- Reset mid-row or mid-load: everything returns to reset values; weights_loaded=0; weights must be reloaded.

Optional Feature:
- Macro: GCN_TA_LEAKY_RELU_EN.
- Defined: the activation maps negative v to v>>>LEAKY_SHIFT (arithmetic shift), in both the pre and post position.
- Undefined: negative values map to 0; LEAKY_SHIFT is unused.

Decomposition:
- Package gcn_ta_pkg: state enum (S_IDLE, S_LOAD, S_READY, S_ACC, S_OUT), functions acc_width(), chunks(), sat_to_data().
- Sub-module gcn_act_lane: one word; signed saturate and activation, parametrised by DATA_W and the leaky option. Instantiate PSYS copies for the pre stage and PSYS for the post stage.

Test Plan:
All scenarios use DATA_W=16, PSYS=4, FEAT_LEN=8, FRAC_BITS=0, K=4.
- Load: W = identity in the first 4 rows, zero elsewhere; mode 0; x = [1,-2,3,4 | 9,9,9,9] → y=[1,0,3,4], row_idx 0, y_valid exactly 1 cycle after the 2nd beat.
- Mode 1, same W, x=[-5,6,-7,8 | 0,0,0,0] → y=[0,6,0,8]; with GCN_TA_LEAKY_RELU_EN the pre-activation maps -5 and -7 to -1 (>>>3), so y=[-1,6,-1,8].
- All W=32767, x all 32767 → each lane saturates to 32767; mode 0 with all x=-32768 → 0.
- Hold y_ready=0 for 5 cycles → y_data and row_idx stable and x_ready=0; stream 5 rows → row_idx 0,1,2,3,0.
- x_last on beat 0 → err_last=1, and the row still completes after 2 beats; load_start during S_ACC is ignored; load_start in S_READY reloads, with weights_loaded=0 until 8 beats are accepted.
- Assert rst mid-row → outputs 0, weights_loaded=0, x_ready=0 until reload.
